// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_HALF_60HZ = (CLK_HZ + 60) / 120;

  // Channel-select width: ceil(log2(n)), never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period, registered clock and strobes.
// Optional tick_rise counter when CLK_DIV_MULTI_RISECNT_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = DEF_HALF_60HZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall
`ifdef CLK_DIV_MULTI_RISECNT_EN
  ,output logic [15:0]     rise_cnt
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             wrap;

  always_comb begin
    // A write landing on the wrap edge must be picked up by that wrap.
    shd_d  = wr ? wr_val : shd_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    wrap   = (act_q != '0) && (cnt_q == act_q - CNT_W'(1));
    if (!en || sync_restart || act_q == '0) begin
      cnt_d = '0;
      out_d = 1'b0;
      act_d = shd_d;
    end else if (wrap) begin
      cnt_d  = '0;
      out_d  = ~out_q;
      rise_d = ~out_q;
      fall_d = out_q;
      act_d  = shd_d;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(DEF_HALF);
      shd_q  <= CNT_W'(DEF_HALF);
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk_out   = out_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

`ifdef CLK_DIV_MULTI_RISECNT_EN
  logic [15:0] rcnt_q, rcnt_d;

  // Held while disabled; only a restart of an enabled channel clears it.
  always_comb begin
    rcnt_d = rcnt_q;
    if (en && sync_restart) rcnt_d = '0;
    else if (rise_d)        rcnt_d = rcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign rise_cnt = rcnt_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / tick generator: NUM_CH independent channels with
// shared write port and phase restart. Define CLK_DIV_MULTI_RISECNT_EN to add rise_cnt.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int          NUM_CH   = 2,
  parameter  int          CNT_W    = 32,
  parameter  int unsigned DEF_HALF = DEF_HALF_60HZ,
  localparam int          CH_W     = clog2_min1(NUM_CH)
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 sync_restart,
  input  logic                 div_wr,
  input  logic [CH_W-1:0]      div_ch,
  input  logic [CNT_W-1:0]     div_val,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick_rise,
  output logic [NUM_CH-1:0]    tick_fall
`ifdef CLK_DIV_MULTI_RISECNT_EN
  ,output logic [NUM_CH*16-1:0] rise_cnt
`endif
);

  // Out-of-range div_ch matches no channel, so such writes fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk          (clk_50mhz),
      .rst_n        (rst_n),
      .en           (en[i]),
      .sync_restart (sync_restart),
      .wr           (div_wr && (div_ch == CH_W'(i))),
      .wr_val       (div_val),
      .clk_out      (clk_out[i]),
      .tick_rise    (tick_rise[i]),
      .tick_fall    (tick_fall[i])
`ifdef CLK_DIV_MULTI_RISECNT_EN
      ,.rise_cnt    (rise_cnt[i*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed steps plus random traffic against a half-period model.
module tb_clk_div_multi;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 4;
  localparam int CH_W     = 2;

  logic              clk_50mhz = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              sync_restart = 1'b0;
  logic              div_wr = 1'b0;
  logic [CH_W-1:0]   div_ch = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic [NUM_CH-1:0] clk_out, tick_rise, tick_fall;
`ifdef CLK_DIV_MULTI_RISECNT_EN
  logic [NUM_CH*16-1:0] rise_cnt;
`endif

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk_50mhz    (clk_50mhz),
    .rst_n        (rst_n),
    .en           (en),
    .sync_restart (sync_restart),
    .div_wr       (div_wr),
    .div_ch       (div_ch),
    .div_val      (div_val),
    .clk_out      (clk_out),
    .tick_rise    (tick_rise),
    .tick_fall    (tick_fall)
`ifdef CLK_DIV_MULTI_RISECNT_EN
    ,.rise_cnt    (rise_cnt)
`endif
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int errors = 0;
  int checks = 0;

  // Model state: clocks elapsed in the current half, half-period in force,
  // pending half-period, output level, strobes, rising-edge tally.
  int elapsed [NUM_CH];
  int half    [NUM_CH];
  int pending [NUM_CH];
  bit level   [NUM_CH];
  bit m_rise  [NUM_CH];
  bit m_fall  [NUM_CH];
  int rises   [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      elapsed[c] = 0; half[c] = DEF_HALF; pending[c] = DEF_HALF;
      level[c] = 0; m_rise[c] = 0; m_fall[c] = 0; rises[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int nxt;
      nxt = (div_wr && int'(div_ch) == c) ? int'(div_val) : pending[c];
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (!en[c] || sync_restart || half[c] == 0) begin
        if (en[c] && sync_restart) rises[c] = 0;
        elapsed[c] = 0; level[c] = 0; half[c] = nxt;
      end else if (elapsed[c] + 1 >= half[c]) begin
        level[c]   = !level[c];
        m_rise[c]  = level[c];
        m_fall[c]  = !level[c];
        if (level[c]) rises[c] = (rises[c] + 1) % 65536;
        elapsed[c] = 0; half[c] = nxt;
      end else begin
        elapsed[c] = elapsed[c] + 1;
      end
      pending[c] = nxt;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] eo, er, ef;
    for (int c = 0; c < NUM_CH; c++) begin
      eo[c] = level[c]; er[c] = m_rise[c]; ef[c] = m_fall[c];
    end
    check("clk_out", 32'(clk_out), 32'(eo));
    check("tick_rise", 32'(tick_rise), 32'(er));
    check("tick_fall", 32'(tick_fall), 32'(ef));
`ifdef CLK_DIV_MULTI_RISECNT_EN
    for (int c = 0; c < NUM_CH; c++)
      check("rise_cnt", 32'(rise_cnt[c*16 +: 16]), 32'(rises[c]));
`endif
  endtask

  task automatic cycle();
    @(posedge clk_50mhz);
    model_step();
    #1 compare_all();
    @(negedge clk_50mhz);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input int ch, input int val);
    div_wr = 1'b1; div_ch = CH_W'(ch); div_val = CNT_W'(val);
    cycle();
    div_wr = 1'b0;
  endtask

  initial begin
    // Reset state
    model_reset();
    #5 compare_all();
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    en = '1;

    // Default half-period 4: rises at 4, 12, 20; falls at 8, 16, 24
    run(24);
    check("rise_after_24", 32'(rises[0]), 32'd3);

    // Shorten ch0 to 3 two cycles into a half; current half still lasts 4
    run(1);
    write(0, 3);
    run(20);

    // ch0 H=4, ch1 H=6, then restart mid-count
    write(0, 4);
    write(1, 6);
    run(15);
    sync_restart = 1'b1;
    cycle();
    sync_restart = 1'b0;
    check("restart_low", 32'(clk_out), 32'd0);
    run(14);

    // H=0 idles the channel, H=1 toggles every cycle
    write(2, 0);
    run(10);
    write(2, 1);
    run(8);

    // Out-of-range channel select changes nothing
    write(3, 7);
    run(12);

    // Disable one channel while high, re-enable
    en = 3'b101;
    run(5);
    en = '1;
    run(8);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) en = NUM_CH'($urandom_range(7));
      div_wr       = ($urandom_range(7) == 0);
      div_ch       = CH_W'($urandom_range(3));
      div_val      = CNT_W'($urandom_range(7));
      sync_restart = ($urandom_range(31) == 0);
      cycle();
    end
    div_wr = 1'b0;
    sync_restart = 1'b0;
    en = '1;
    run(10);

    // Asynchronous reset mid-count
    #3 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    run(18);
    check("rise_after_reset", 32'(rises[1]), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
